cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//   Synthesizable run controller for the simple processor (top). Replaces a fixed reset-then-N-clocks
//   program harness. Sequences CPU reset, gates CPU clock-enable, counts executed cycles and detects
//   end of program: halt signal, PC self-loop stall, cycle-budget timeout or abort. Selects one of
//   several preloaded programs. Reports status and cycle count. Sits beside top, one level above it.
// PARAMETERS
//   PC_W         8    width of CPU program counter
//   CYCLE_W      16   width of cycle counter; MAX_CYCLES < 2**CYCLE_W
//   MAX_CYCLES   220  RUN-cycle budget before TIMEOUT (>=1)
//   RESET_CYCLES 1    cycles cpu_reset held high after start (>=1)
//   STALL_LIMIT  4    consecutive unchanged-PC cycles that mean halted; 0 disables
//   PROG_W       2    width of program select (2**PROG_W program images)
// PORTS
//   clk         in   1        system clock, rising edge
//   reset       in   1        synchronous, active-high
//   start       in   1        begin run; sampled in IDLE only
//   abort       in   1        terminate run; sampled in RST/RUN only
//   prog_sel    in   PROG_W   program to run; sampled with start
//   cpu_pc      in   PC_W     CPU program counter
//   cpu_halt    in   1        CPU halt instruction retired
//   cpu_reset   out  1        synchronous reset to CPU
//   cpu_en      out  1        CPU clock enable
//   prog_id     out  PROG_W   latched program select (drives memory image mux)
//   busy        out  1        high in RST and RUN
//   done        out  1        one-cycle pulse at run end
//   status      out  2        00 HALT, 01 STALL, 10 TIMEOUT, 11 ABORT; held until next start
//   cycle_count out  CYCLE_W  RUN cycles executed; held until next start
// BEHAVIOUR
//   - All outputs registered. Reset: state IDLE, cpu_reset=1, cpu_en=0, prog_id=0, busy=0, done=0,
//     status=00, cycle_count=0, stall counter=0. Reset wins over every input, any state.
//   - IDLE: cpu_en=0; cpu_reset unchanged (1 after reset, 0 after a run so CPU state is inspectable).
//     start=1 -> RST next cycle; prog_id<=prog_sel, cycle_count<=0, status<=00, stall cnt<=0.
//   - RST: cpu_reset=1, cpu_en=1 for exactly RESET_CYCLES cycles -> RUN. abort -> DONE/ABORT.
//   - RUN: cpu_reset=0, cpu_en=1. Each RUN cycle cycle_count+=1, terminating cycle included.
//     pc_prev<=cpu_pc each cycle; compare starts on 2nd RUN cycle. cpu_pc==pc_prev -> stall cnt+1,
//     else stall cnt<=0. Exit priority same cycle: abort > cpu_halt > stall cnt reaches STALL_LIMIT
//     > cycle_count+1==MAX_CYCLES. On exit: status set, -> DONE.
//   - DONE: one cycle; done=1, busy=0, cpu_en=0, cpu_reset=0 -> IDLE. start here ignored.
//   - start in RST/RUN/DONE ignored; abort in IDLE/DONE ignored; prog_sel changes outside IDLE ignored.
//   - Latency: start at edge k -> cpu_reset=1,busy=1 after k+1; first RUN cycle after k+1+RESET_CYCLES.
//   - cycle_count never exceeds MAX_CYCLES (no wrap possible given parameter constraint).
// STRUCTURE
//   - Shared include cpu_run_ctrl_defs.vh: state encodings (IDLE,RST,RUN,DONE), status codes.
//   - Sub-module pc_stall_detector (clk, reset, clear, en, pc, stalled): pc_prev reg + counter.
//   - Top level: FSM, reset-cycle counter, cycle counter, output registers.
// TESTING (defaults unless stated)
//   - Reset then start, prog_sel=2, cpu_halt at 10th RUN cycle -> done pulse, status=00,
//     cycle_count=10, prog_id=2, cpu_reset high exactly 1 cycle, cpu_en low after DONE.
//   - cpu_pc constant 0x1F from 3rd RUN cycle -> status=01 after 4 equal compares, cycle_count=7.
//   - PC increments forever, no halt -> status=10, cycle_count=220, busy high 221 cycles (1 RST).
//   - RESET_CYCLES=3: cpu_reset high 3 cycles; abort at RUN cycle 5 -> status=11, cycle_count=5.
//   - cpu_halt, stall and timeout all on cycle 220 -> status=00; start held during RUN ignored.
//   - reset asserted mid-RUN -> next cycle IDLE, cpu_reset=1, outputs at reset values, no done pulse.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared state encodings, status codes and sizing helper for the run controller
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RST  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } run_state_t;

    localparam logic [1:0] STAT_HALT    = 2'b00;
    localparam logic [1:0] STAT_STALL   = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;
    localparam logic [1:0] STAT_ABORT   = 2'b11;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_pc_stall_detector.sv
// rtl/cpu_run_ctrl_pc_stall_detector.sv - flags a CPU parked on one PC for STALL_LIMIT consecutive compares
module pc_stall_detector
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            stalled
);

    localparam int CNT_W = cnt_width(STALL_LIMIT);

    logic [PC_W-1:0]  pc_prev;
    logic             prev_valid;
    logic [CNT_W-1:0] cnt;
    logic             same;

    // No compare on the first enabled cycle: pc_prev still holds a pre-run value.
    assign same    = en && prev_valid && (pc == pc_prev);
    assign stalled = (STALL_LIMIT != 0) && same && (cnt == CNT_W'(STALL_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_prev    <= '0;
            prev_valid <= 1'b0;
            cnt        <= '0;
        end else begin
            pc_prev <= pc;
            if (clear) begin
                prev_valid <= 1'b0;
                cnt        <= '0;
            end else if (en) begin
                prev_valid <= 1'b1;
                if (!same)
                    cnt <= '0;
                else if (cnt != {CNT_W{1'b1}})
                    cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - sequences CPU reset/enable, counts RUN cycles and classifies how a program ended
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int CYCLE_W      = 16,
    parameter int MAX_CYCLES   = 220,
    parameter int RESET_CYCLES = 1,
    parameter int STALL_LIMIT  = 4,
    parameter int PROG_W       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PROG_W-1:0]  prog_sel,
    input  logic [PC_W-1:0]    cpu_pc,
    input  logic               cpu_halt,
    output logic               cpu_reset,
    output logic               cpu_en,
    output logic [PROG_W-1:0]  prog_id,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam int RC_W = cnt_width(RESET_CYCLES);

    run_state_t         state, state_next;
    logic [RC_W-1:0]    rst_cnt, rst_cnt_next;
    logic [CYCLE_W-1:0] count_next, count_inc;
    logic [1:0]         status_next, exit_status;
    logic [PROG_W-1:0]  prog_id_next;
    logic               cpu_reset_next, cpu_en_next, busy_next, done_next;
    logic               stall_clear, stalled, run_exit;

    pc_stall_detector #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk     (clk),
        .reset   (reset),
        .clear   (stall_clear),
        .en      (state == ST_RUN),
        .pc      (cpu_pc),
        .stalled (stalled)
    );

    assign count_inc = cycle_count + CYCLE_W'(1);

    // Exit priority within one RUN cycle: abort, halt, stall, budget.
    always_comb begin
        run_exit    = 1'b1;
        exit_status = STAT_HALT;
        if (abort)
            exit_status = STAT_ABORT;
        else if (cpu_halt)
            exit_status = STAT_HALT;
        else if (stalled)
            exit_status = STAT_STALL;
        else if (count_inc == CYCLE_W'(MAX_CYCLES))
            exit_status = STAT_TIMEOUT;
        else
            run_exit = 1'b0;
    end

    always_comb begin
        state_next     = state;
        rst_cnt_next   = rst_cnt;
        count_next     = cycle_count;
        status_next    = status;
        prog_id_next   = prog_id;
        cpu_reset_next = cpu_reset;
        cpu_en_next    = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        stall_clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_RST;
                    rst_cnt_next   = '0;
                    count_next     = '0;
                    status_next    = STAT_HALT;
                    prog_id_next   = prog_sel;
                    cpu_reset_next = 1'b1;
                    cpu_en_next    = 1'b1;
                    busy_next      = 1'b1;
                    stall_clear    = 1'b1;
                end
            end
            ST_RST: begin
                cpu_reset_next = 1'b1;
                cpu_en_next    = 1'b1;
                busy_next      = 1'b1;
                if (abort) begin
                    state_next     = ST_DONE;
                    status_next    = STAT_ABORT;
                    cpu_reset_next = 1'b0;
                    cpu_en_next    = 1'b0;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                end else if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                    state_next     = ST_RUN;
                    cpu_reset_next = 1'b0;
                end else begin
                    rst_cnt_next = rst_cnt + RC_W'(1);
                end
            end
            ST_RUN: begin
                count_next     = count_inc;
                cpu_reset_next = 1'b0;
                cpu_en_next    = 1'b1;
                busy_next      = 1'b1;
                if (run_exit) begin
                    state_next  = ST_DONE;
                    status_next = exit_status;
                    cpu_en_next = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                end
            end
            ST_DONE: begin
                state_next     = ST_IDLE;
                cpu_reset_next = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            status      <= STAT_HALT;
            prog_id     <= '0;
            cpu_reset   <= 1'b1;
            cpu_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            rst_cnt     <= rst_cnt_next;
            cycle_count <= count_next;
            status      <= status_next;
            prog_id     <= prog_id_next;
            cpu_reset   <= cpu_reset_next;
            cpu_en      <= cpu_en_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

endmodule
